// File: rtl/term_pkg.sv
// Shared constants, control-byte codes and FSM state encoding for the UART terminal writer.
package term_pkg;

  localparam int unsigned DEF_COLS = 80;
  localparam int unsigned DEF_ROWS = 30;
  localparam logic [7:0]  DEF_FILL = 8'h20;

  localparam int unsigned COL_W  = 7;
  localparam int unsigned ROW_W  = 5;
  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 8;

  localparam logic [7:0] CH_BS       = 8'h08;
  localparam logic [7:0] CH_LF       = 8'h0A;
  localparam logic [7:0] CH_CR       = 8'h0D;
  localparam logic [7:0] CH_ESC      = 8'h1B;
  localparam logic [7:0] CH_LBRACKET = 8'h5B;
  localparam logic [7:0] CH_J        = 8'h4A;

  typedef enum logic [2:0] {
    ST_CLR_ALL = 3'd0,
    ST_IDLE    = 3'd1,
    ST_ESC     = 3'd2,
    ST_CSI     = 3'd3,
    ST_CLR_ROW = 3'd4
  } state_t;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/uart_term_writer.sv
// Turns a UART byte stream into character-buffer writes: printable text, CR, BS,
// a minimal CSI parser (ESC [ ... J clears the screen) and row/screen clearing.
module uart_term_writer
  import term_pkg::*;
#(
  parameter int unsigned COLS = DEF_COLS,
  parameter int unsigned ROWS = DEF_ROWS,
  parameter logic [7:0]  FILL = DEF_FILL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [ADDR_W-1:0] o_address,
  output logic [DATA_W-1:0] o_data,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_cursor
);

  state_t              r_state;
  logic [COL_W-1:0]    r_col;
  logic [ROW_W-1:0]    r_row;
  logic                r_we;
  logic [ADDR_W-1:0]   r_address;
  logic [DATA_W-1:0]   r_data;

  state_t              w_state_nxt;
  logic [COL_W-1:0]    w_col_nxt;
  logic [ROW_W-1:0]    w_row_nxt;
  logic                w_we_nxt;
  logic [ADDR_W-1:0]   w_address_nxt;
  logic [DATA_W-1:0]   w_data_nxt;

  logic                w_accept;
  logic                w_col_last;
  logic                w_row_last;
  logic [ROW_W-1:0]    w_row_inc;
  logic [ADDR_W-1:0]   w_cur_addr;

  assign o_ready    = (r_state == ST_IDLE) || (r_state == ST_ESC) || (r_state == ST_CSI);
  assign w_accept   = i_valid && o_ready;
  assign w_col_last = (r_col == COL_W'(COLS - 1));
  assign w_row_last = (r_row == ROW_W'(ROWS - 1));
  assign w_row_inc  = w_row_last ? '0 : r_row + ROW_W'(1);
  assign w_cur_addr = {1'b0, r_row, r_col};

  assign o_address  = r_address;
  assign o_data     = r_data;
  assign o_we       = r_we;
  assign o_cursor   = w_cur_addr;

  // Next-state and write decode; the col/row pair doubles as the clear sequencer.
  always_comb begin
    w_state_nxt   = r_state;
    w_col_nxt     = r_col;
    w_row_nxt     = r_row;
    w_we_nxt      = 1'b0;
    w_address_nxt = r_address;
    w_data_nxt    = r_data;

    case (r_state)
      ST_CLR_ALL: begin
        w_we_nxt      = 1'b1;
        w_address_nxt = w_cur_addr;
        w_data_nxt    = FILL;
        if (w_col_last) begin
          w_col_nxt = '0;
          w_row_nxt = w_row_inc;
          if (w_row_last) begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_col_nxt = r_col + COL_W'(1);
        end
      end

      ST_CLR_ROW: begin
        w_we_nxt      = 1'b1;
        w_address_nxt = w_cur_addr;
        w_data_nxt    = FILL;
        if (w_col_last) begin
          w_col_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_col_nxt = r_col + COL_W'(1);
        end
      end

      ST_IDLE: begin
        if (w_accept) begin
          if (is_printable(i_data)) begin
            w_we_nxt      = 1'b1;
            w_address_nxt = w_cur_addr;
            w_data_nxt    = i_data;
            if (w_col_last) begin
              w_col_nxt   = '0;
              w_row_nxt   = w_row_inc;
              w_state_nxt = ST_CLR_ROW;
            end else begin
              w_col_nxt = r_col + COL_W'(1);
            end
          end else if (i_data == CH_CR) begin
            w_col_nxt   = '0;
            w_row_nxt   = w_row_inc;
            w_state_nxt = ST_CLR_ROW;
          end else if (i_data == CH_BS) begin
            if (r_col != '0) begin
              w_col_nxt     = r_col - COL_W'(1);
              w_we_nxt      = 1'b1;
              w_address_nxt = {1'b0, r_row, r_col - COL_W'(1)};
              w_data_nxt    = FILL;
            end
          end else if (i_data == CH_ESC) begin
            w_state_nxt = ST_ESC;
          end else if (i_data == CH_LF) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end

      ST_ESC: begin
        if (w_accept) begin
          w_state_nxt = (i_data == CH_LBRACKET) ? ST_CSI : ST_IDLE;
        end
      end

      ST_CSI: begin
        if (w_accept) begin
          if ((i_data >= 8'h30) && (i_data <= 8'h3F)) begin
            w_state_nxt = ST_CSI;
          end else if ((i_data == CH_J)) begin
            w_state_nxt = ST_CLR_ALL;
            w_col_nxt   = '0;
            w_row_nxt   = '0;
          end else begin
            // Non-J finals and malformed bytes both just end the sequence.
            w_state_nxt = ST_IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = ST_CLR_ALL;
        w_col_nxt   = '0;
        w_row_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_CLR_ALL;
      r_col     <= '0;
      r_row     <= '0;
      r_we      <= 1'b0;
      r_address <= '0;
      r_data    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_col     <= w_col_nxt;
      r_row     <= w_row_nxt;
      r_we      <= w_we_nxt;
      r_address <= w_address_nxt;
      r_data    <= w_data_nxt;
    end
  end

endmodule

// File: tb/tb_uart_term_writer.sv
// Directed bench for uart_term_writer: reset, full clear, text, BS, CR/wrap, CSI and mid-clear reset.
module tb_uart_term_writer;

  logic        clk;
  logic        rst;
  logic [7:0]  i_data;
  logic        i_valid;
  logic        o_ready;
  logic [12:0] o_address;
  logic [7:0]  o_data;
  logic        o_we;
  logic [12:0] o_cursor;

  int n_pass  = 0;
  int n_total = 0;

  uart_term_writer dut (
    .clk       (clk),
    .rst       (rst),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .o_address (o_address),
    .o_data    (o_data),
    .o_we      (o_we),
    .o_cursor  (o_cursor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] addr_of(input int idx);
    int r;
    int c;
    r = idx / 80;
    c = idx % 80;
    return 13'((r << 7) | c);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    while (o_ready !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    if (o_ready !== 1'b1) begin
      n_total++;
      $display("FAIL send_timeout: o_ready=%b required 1 before byte %h", o_ready, b);
    end
    i_data  = b;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
  endtask

  // Observes a clear from the current sample until o_ready rises.
  task automatic measure_clear(input int base, output int low, output int writes, output int bad);
    low = 0;
    writes = 0;
    bad = 0;
    for (int c = 0; c < 3000; c++) begin
      if (o_we === 1'b1) begin
        if (o_address !== addr_of(base + writes) || o_data !== 8'h20) bad++;
        writes++;
      end
      if (o_ready === 1'b1) break;
      low++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_valid = 1'b0;
    i_data = 8'h00;
    repeat (3) tick();
    n_total++;
    if ({o_we, o_ready, o_cursor, o_address, o_data} !== 35'd0) begin
      $display("FAIL reset_outputs: we=%b ready=%b cur=%h addr=%h data=%h required all 0",
               o_we, o_ready, o_cursor, o_address, o_data);
    end else n_pass++;
  endtask

  task automatic check_full_clear(input string tag);
    int low, writes, bad;
    measure_clear(0, low, writes, bad);
    n_total++;
    if (low !== 2400) $display("FAIL %s_ready_low: got %0d required 2400", tag, low);
    else n_pass++;
    n_total++;
    if (writes !== 2400 || bad !== 0)
      $display("FAIL %s_writes: got %0d writes %0d bad required 2400 writes 0 bad", tag, writes, bad);
    else n_pass++;
    n_total++;
    if (o_cursor !== 13'h000) $display("FAIL %s_cursor: got %h required 000", tag, o_cursor);
    else n_pass++;
  endtask

  task automatic test_clr_all();
    rst = 1'b0;
    check_full_clear("clr_all");
    tick();
    n_total++;
    if (o_we !== 1'b0 || o_ready !== 1'b1)
      $display("FAIL clr_all_idle: we=%b ready=%b required we=0 ready=1", o_we, o_ready);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    i_data = 8'h41;
    i_valid = 1'b1;
    tick();
    n_total++;
    if (o_we !== 1'b1 || o_address !== 13'h000 || o_data !== 8'h41)
      $display("FAIL ab_first: we=%b addr=%h data=%h required 1/000/41", o_we, o_address, o_data);
    else n_pass++;
    i_data = 8'h42;
    tick();
    i_valid = 1'b0;
    n_total++;
    if (o_we !== 1'b1 || o_address !== 13'h001 || o_data !== 8'h42 || o_cursor !== 13'h002)
      $display("FAIL ab_second: we=%b addr=%h data=%h cur=%h required 1/001/42/002",
               o_we, o_address, o_data, o_cursor);
    else n_pass++;
    tick();
    n_total++;
    if (o_we !== 1'b0) $display("FAIL ab_we_drop: we=%b required 0", o_we);
    else n_pass++;
  endtask

  task automatic test_backspace();
    int writes;
    send_byte(8'h43);
    send_byte(8'h44);
    send_byte(8'h45);
    send_byte(8'h08);
    n_total++;
    if (o_we !== 1'b1 || o_address !== 13'h004 || o_data !== 8'h20 || o_cursor !== 13'h004)
      $display("FAIL bs_first: we=%b addr=%h data=%h cur=%h required 1/004/20/004",
               o_we, o_address, o_data, o_cursor);
    else n_pass++;
    writes = 0;
    for (int k = 0; k < 5; k++) begin
      send_byte(8'h08);
      if (o_we === 1'b1) writes++;
    end
    n_total++;
    if (writes !== 4 || o_we !== 1'b0 || o_cursor !== 13'h000)
      $display("FAIL bs_more: writes=%0d last_we=%b cur=%h required 4/0/000", writes, o_we, o_cursor);
    else n_pass++;
  endtask

  task automatic test_cr_wrap();
    int low, writes, bad;
    for (int k = 0; k < 29; k++) send_byte(8'h0D);
    for (int k = 0; k < 10; k++) send_byte(8'h78);
    n_total++;
    if (o_cursor !== 13'((29 << 7) | 10)) $display("FAIL cr_setup_cursor: got %h required e8a", o_cursor);
    else n_pass++;
    send_byte(8'h0D);
    n_total++;
    if (o_cursor !== 13'h000 || o_ready !== 1'b0 || o_we !== 1'b0)
      $display("FAIL cr_start: cur=%h ready=%b we=%b required 000/0/0", o_cursor, o_ready, o_we);
    else n_pass++;
    measure_clear(0, low, writes, bad);
    n_total++;
    if (low !== 80 || writes !== 80 || bad !== 0)
      $display("FAIL cr_row_clear: low=%0d writes=%0d bad=%0d required 80/80/0", low, writes, bad);
    else n_pass++;
    n_total++;
    if (o_cursor !== 13'h000) $display("FAIL cr_end_cursor: got %h required 000", o_cursor);
    else n_pass++;
  endtask

  task automatic test_col_wrap();
    int low, writes, bad;
    for (int k = 0; k < 80; k++) send_byte(8'h61);
    n_total++;
    if (o_we !== 1'b1 || o_address !== 13'h04F || o_data !== 8'h61 || o_cursor !== 13'h080 || o_ready !== 1'b0)
      $display("FAIL wrap_last: we=%b addr=%h data=%h cur=%h ready=%b required 1/04f/61/080/0",
               o_we, o_address, o_data, o_cursor, o_ready);
    else n_pass++;
    tick();
    measure_clear(80, low, writes, bad);
    n_total++;
    if (low !== 79 || writes !== 80 || bad !== 0 || o_cursor !== 13'h080)
      $display("FAIL wrap_row_clear: low=%0d writes=%0d bad=%0d cur=%h required 79/80/0/080",
               low, writes, bad, o_cursor);
    else n_pass++;
  endtask

  task automatic test_ignored();
    int writes;
    logic [7:0] seq [4];
    seq = '{8'h0A, 8'h7F, 8'h01, 8'h1F};
    writes = 0;
    for (int k = 0; k < 4; k++) begin
      send_byte(seq[k]);
      if (o_we === 1'b1) writes++;
    end
    n_total++;
    if (writes !== 0 || o_cursor !== 13'h080 || o_ready !== 1'b1)
      $display("FAIL ignored: writes=%0d cur=%h ready=%b required 0/080/1", writes, o_cursor, o_ready);
    else n_pass++;
  endtask

  task automatic test_csi();
    int writes;
    logic [7:0] seq [8];
    seq = '{8'h1B, 8'h51, 8'h1B, 8'h5B, 8'h33, 8'h31, 8'h6D, 8'h58};
    writes = 0;
    for (int k = 0; k < 8; k++) begin
      send_byte(seq[k]);
      if (o_we === 1'b1) writes++;
    end
    n_total++;
    if (writes !== 1 || o_address !== 13'h080 || o_data !== 8'h58 || o_cursor !== 13'h081)
      $display("FAIL csi_sgr: writes=%0d addr=%h data=%h cur=%h required 1/080/58/081",
               writes, o_address, o_data, o_cursor);
    else n_pass++;
    send_byte(8'h1B);
    send_byte(8'h5B);
    send_byte(8'h32);
    send_byte(8'h4A);
    n_total++;
    if (o_ready !== 1'b0 || o_cursor !== 13'h000 || o_we !== 1'b0)
      $display("FAIL csi_j_start: ready=%b cur=%h we=%b required 0/000/0", o_ready, o_cursor, o_we);
    else n_pass++;
    check_full_clear("csi_j");
  endtask

  task automatic test_rst_mid_clear();
    tick();
    send_byte(8'h0D);
    repeat (39) tick();
    n_total++;
    if (o_we !== 1'b1 || o_address !== 13'h080 + 13'd38)
      $display("FAIL mid_pre: we=%b addr=%h required 1/0a6", o_we, o_address);
    else n_pass++;
    rst = 1'b1;
    tick();
    n_total++;
    if (o_we !== 1'b0 || o_ready !== 1'b0 || o_cursor !== 13'h000 || o_address !== 13'h000 || o_data !== 8'h00)
      $display("FAIL mid_rst: we=%b ready=%b cur=%h addr=%h data=%h required all 0",
               o_we, o_ready, o_cursor, o_address, o_data);
    else n_pass++;
    rst = 1'b0;
    check_full_clear("mid_reclear");
  endtask

  initial begin
    test_reset();
    test_clr_all();
    test_back_to_back();
    test_backspace();
    test_cr_wrap();
    test_col_wrap();
    test_ignored();
    test_csi();
    test_rst_mid_clear();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_term_writer.md
UART_TERM_WRITER -- requirements
Module: uart_term_writer

Interface
REQ-001 Parameter COLS, default 80, text columns per row.
REQ-002 Parameter ROWS, default 30, text rows per screen.
REQ-003 Parameter FILL, default 8'h20, character written when clearing cells.
REQ-004 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  system/pixel clock; all logic on its rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 i_data  input  8  received UART byte.
REQ-008 i_valid  input  1  i_data is valid this cycle.
REQ-009 o_ready  output  1  block accepts a byte this cycle.
REQ-010 o_address  output  13  charbuf write address {1'b0, row[4:0], col[6:0]}.
REQ-011 o_data  output  8  character to write.
REQ-012 o_we  output  1  one-cycle charbuf write strobe.
REQ-013 o_cursor  output  13  current cursor address, same format as o_address.

Function
REQ-014 A byte is accepted only in a cycle where i_valid and o_ready are both 1; bytes presented while o_ready is 0 are not consumed.
REQ-015 FSM states: CLR_ALL, IDLE, ESC, CSI, CLR_ROW; o_ready is 1 exactly in IDLE, ESC and CSI, decoded from the state register.
REQ-016 Printable byte (0x20..0x7E) accepted in cycle N: o_we=1 in N+1 with o_address at the cursor and o_data=byte; col increments.
REQ-017 Printable throughput: one byte per cycle while no row advance occurs.
REQ-018 Writing at col COLS-1: col wraps to 0 and a row advance follows.
REQ-019 CR (0x0D): col<=0, then a row advance.
REQ-020 LF (0x0A) is ignored.
REQ-021 BS (0x08) with col>0: col decrements and FILL is written at the new col.
REQ-022 BS with col=0: no write, cursor unchanged.
REQ-023 Row advance: row<=row+1, with row ROWS-1 wrapping to 0. The state then enters CLR_ROW and writes FILL to cols 0..COLS-1 of the new row, one cell per cycle (COLS cycles). It then returns to IDLE with col=0.
REQ-024 ESC (0x1B) in IDLE: go to ESC, no write.
REQ-025 In ESC, '[' goes to CSI; any other byte is discarded and the state returns to IDLE.
REQ-026 In CSI, bytes 0x30..0x3F are parameter bytes: discarded, state stays CSI.
REQ-027 In CSI, a final byte 0x40..0x7E ends the sequence. Final 'J' goes to CLR_ALL with the cursor at (0,0); any other final returns to IDLE with no write.
REQ-028 Any other byte received in CSI aborts to IDLE.
REQ-029 All other control bytes (0x00..0x1F not listed, and 0x7F) are ignored.
REQ-030 CLR_ALL writes FILL to every cell, row-major from (0,0) to (ROWS-1,COLS-1), one per cycle (ROWS*COLS cycles), then goes to IDLE with the cursor at (0,0).
REQ-031 o_we is 0 in every cycle not covered by REQ-016, REQ-021, REQ-023 or REQ-030.
REQ-032 o_address never carries row>=ROWS or col>=COLS.
REQ-033 o_cursor always reflects the committed cursor position; it is updated in the same cycle as the write it causes.

Reset
REQ-034 While rst=1: o_we=0, o_ready=0, cursor=(0,0), o_address=0, o_data=0.
REQ-035 On the first cycle after rst deasserts, the state is CLR_ALL.
REQ-036 rst asserted mid-operation (CLR_ROW, CLR_ALL, ESC or CSI) aborts that operation in the next cycle; partial clears are not resumed.

Structure
REQ-037 Package term_pkg holds COLS/ROWS defaults, FILL, the control-byte constants (CR, LF, BS, ESC, '[', 'J') and the state enumeration.
REQ-038 The block is a single module with no sub-module; one shared col/row counter pair serves both cursor and clear sequencing.

Verification
REQ-039 Release rst -> o_ready stays 0 for exactly 2400 cycles, 2400 o_we pulses with o_data=0x20 over addresses 0x000..{29,79}, then o_ready=1 and o_cursor=0.
REQ-040 Send "AB" on back-to-back cycles -> o_we with (addr 0x000, 0x41) then (0x001, 0x42); o_cursor=0x002.
REQ-041 At cursor (0,5) send BS -> one write (0x004, 0x20); o_cursor=0x004. Then send 5 more BS -> 4 writes, and the final BS is a no-op.
REQ-042 At row 29, col 10 send CR -> o_ready low for 80 cycles, 80 writes of 0x20 to row 0, then o_cursor=0x000.
REQ-043 Send ESC '[' '3' '1' 'm' 'X' -> only one write, (cursor, 0x58); ESC '[' '2' 'J' -> full 2400-cycle clear and cursor home.
REQ-044 Assert rst during CLR_ROW cycle 40 -> o_we drops next cycle, and a fresh full clear starts after release.
